// File: rtl/demux_select_sequencer_pkg.sv
// Shared constants and state encoding for the 1x8 demux select sequencer.
package demux_select_sequencer_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDwell = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/demux_next_channel.sv
// Combinational channel finder: the next enabled channel above cur, and the lowest enabled one.
module demux_next_channel
  import demux_select_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              found,
  output logic [SEL_W-1:0]  first
);

  // Scan from the top down so that the lowest qualifying index is the last one written.
  always_comb begin
    next  = '0;
    found = 1'b0;
    first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        if (i > int'(cur)) begin
          next  = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demux_select_sequencer.sv
// Steps the demux select lines through a masked channel set, holding each for a dwell time.
module demux_select_sequencer
  import demux_select_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               d_in,
  output logic               d,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NUM_CH-1:0]  nc_mask;
  logic [DWELL_W-1:0] dwell_src, reload;
  logic [SEL_W-1:0]   nc_next, nc_first;
  logic               nc_found;

  // In IDLE the live inputs are about to be snapshotted, so look at them directly.
  assign nc_mask   = (state_q == StIdle) ? ch_mask : mask_q;
  assign dwell_src = (state_q == StIdle) ? dwell : dwell_q;
  assign reload    = (dwell_src == '0) ? DWELL_W'(1) : dwell_src;

  demux_next_channel u_next_channel (
    .mask  (nc_mask),
    .cur   (sel_q),
    .next  (nc_next),
    .found (nc_found),
    .first (nc_first)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          mask_d  = ch_mask;
          dwell_d = dwell;
          if (ch_mask != '0) begin
            state_d = StDwell;
            sel_d   = nc_first;
            cnt_d   = reload;
            busy_d  = 1'b1;
          end else begin
            state_d = StDone;
            sel_d   = '0;
          end
        end
      end
      StDwell: begin
        if (stop) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if (cnt_q <= DWELL_W'(1)) begin
          if (nc_found) begin
            sel_d  = nc_next;
            cnt_d  = reload;
            busy_d = 1'b1;
          end else if (continuous) begin
            // A lone enabled channel wraps onto itself, so the select value does not change.
            sel_d  = nc_first;
            cnt_d  = reload;
            busy_d = 1'b1;
          end else begin
            state_d = StDone;
            sel_d   = '0;
          end
        end else begin
          cnt_d  = cnt_q - DWELL_W'(1);
          busy_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        sel_d   = '0;
        done_d  = !stop;
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {s2, s1, s0} = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign d            = d_in & (state_q == StDwell);

endmodule

// File: tb/tb_demux_select_sequencer.sv
// Randomized bench for demux_select_sequencer against an arithmetic schedule model.
module tb_demux_select_sequencer;

  localparam int NO_STOP = 1000000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       d_in;
  logic       d;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  demux_select_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .d_in       (d_in),
    .d          (d),
    .s0         (s0),
    .s1         (s1),
    .s2         (s2),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 0 samples start. Expected outputs after edge t: while t < stop edge, the run holds
  // channel L[(t/D) % n] for t < n*D (any t if continuous); a single pass is idle at t = n*D
  // and pulses done at t = n*D + 1. An empty mask pulses done at t = 1.
  task automatic run_scenario(input string name, input logic [7:0] m, input int dw,
                              input bit cont, input int t_s, input bit glitch);
    int         chans[$];
    int         n;
    int         dd;
    int         tmax;
    logic [2:0] es;
    logic       eb;
    logic       ed;
    chans.delete();
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    n  = chans.size();
    dd = (dw == 0) ? 1 : dw;
    if (n == 0) tmax = 4;
    else if (cont) tmax = t_s + 3;
    else tmax = (t_s + 3 < n * dd + 4) ? t_s + 3 : n * dd + 4;
    ch_mask    = m;
    dwell      = 8'(dw);
    continuous = cont;
    start      = 1'b1;
    stop       = 1'b0;
    for (int t = 0; t <= tmax; t++) begin
      @(posedge clk);
      #1;
      es = 3'd0;
      eb = 1'b0;
      ed = 1'b0;
      if (t < t_s) begin
        if (n == 0) begin
          ed = (t == 1);
        end else if (cont || t < n * dd) begin
          eb = 1'b1;
          es = 3'(chans[(t / dd) % n]);
        end else begin
          ed = (t == n * dd + 1);
        end
      end
      checks++;
      if ({s2, s1, s0} !== es || busy !== eb || done !== ed) begin
        failures++;
        $display("FAIL %s t=%0d got sel=%0d busy=%b done=%b expected sel=%0d busy=%b done=%b",
                 name, t, {s2, s1, s0}, busy, done, es, eb, ed);
      end
      start = 1'b0;
      stop  = (t + 1 == t_s);
      if (glitch && (t + 1 <= n * dd - 1) && (t + 1 < t_s)) begin
        start   = 1'($urandom_range(0, 1));
        ch_mask = 8'($urandom);
      end
      d_in = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (d !== (d_in & eb)) begin
        failures++;
        $display("FAIL %s_d t=%0d got d=%b expected %b", name, t, d, d_in & eb);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    d_in = 1'b1;
    #1;
    checks++;
    if ({s2, s1, s0, busy, done, d} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got sel/busy/done/d=%b expected 000000",
               {s2, s1, s0, busy, done, d});
    end
    start   = 1'b1;
    ch_mask = 8'hFF;
    dwell   = 8'd2;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({s2, s1, s0, busy, done, d} !== 6'b0) begin
        failures++;
        $display("FAIL reset_held got sel/busy/done/d=%b expected 000000",
                 {s2, s1, s0, busy, done, d});
      end
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_full_pass();
    run_scenario("full_pass", 8'hFF, 5, 1'b0, NO_STOP, 1'b0);
  endtask

  task automatic test_sparse_continuous();
    // Stop is sampled at edge 9, while the second visit to channel 5 is in progress.
    run_scenario("sparse_cont", 8'b1010_0100, 2, 1'b1, 9, 1'b0);
  endtask

  task automatic test_edge_cases();
    run_scenario("empty_mask", 8'h00, 3, 1'b0, NO_STOP, 1'b0);
    run_scenario("mask81_dwell0", 8'h81, 0, 1'b0, NO_STOP, 1'b0);
    ch_mask = 8'h0F;
    dwell   = 8'd2;
    start   = 1'b1;
    stop    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {s2, s1, s0} !== 3'd0) begin
        failures++;
        $display("FAIL start_stop_idle got busy=%b done=%b sel=%0d expected 0 0 0",
                 busy, done, {s2, s1, s0});
      end
    end
  endtask

  task automatic test_robustness();
    run_scenario("robust", 8'hFF, 4, 1'b0, NO_STOP, 1'b1);
  endtask

  task automatic test_async_reset_mid_dwell();
    ch_mask    = 8'hFF;
    dwell      = 8'd4;
    continuous = 1'b0;
    d_in       = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    checks++;
    if ({s2, s1, s0} !== 3'd3 || busy !== 1'b1 || d !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ch3 got sel=%0d busy=%b d=%b expected 3 1 1",
               {s2, s1, s0}, busy, d);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s2, s1, s0, busy, done, d} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_dwell got sel/busy/done/d=%b expected 000000",
               {s2, s1, s0, busy, done, d});
    end
    @(negedge clk) rst = 1'b0;
    run_scenario("restart", 8'b0110_1000, 1, 1'b0, NO_STOP, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] m;
    int         dw;
    bit         cont;
    int         t_s;
    for (int k = 0; k < 20; k++) begin
      m = 8'($urandom);
      if ($urandom_range(0, 5) == 0) m = 8'h00;
      dw   = int'($urandom_range(0, 4));
      cont = 1'($urandom_range(0, 1));
      if (cont || $urandom_range(0, 2) == 0) t_s = int'($urandom_range(1, 30));
      else t_s = NO_STOP;
      run_scenario("random", m, dw, cont, t_s, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    ch_mask    = 8'h00;
    dwell      = 8'd0;
    d_in       = 1'b0;
    test_reset();
    test_full_pass();
    test_sparse_continuous();
    test_edge_cases();
    test_robustness();
    test_async_reset_mid_dwell();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_select_sequencer.md
Name: demux_select_sequencer

Overview:
Upstream driver for the 1x8 demultiplexer. It generates the select lines s2/s1/s0 and the data bit d, stepping through a masked set of the 8 output channels. Each selected channel is held for a programmable dwell time. Runs single-shot or continuously, with a start/stop/busy/done handshake to the controlling logic.

Parameters:
DWELL_W, 8, width of the dwell-time input and of the internal dwell counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sequence; sampled only in IDLE
stop  input  1  abort the sequence; sampled in any state
continuous  input  1  0 = single pass, 1 = wrap forever until stop
ch_mask  input  8  bit i = 1 enables channel i; snapshotted at start
dwell  input  DWELL_W  cycles per channel (0 treated as 1); snapshotted at start
d_in  input  1  data bit to route through the demux
d  output  1  demux data input; equals d_in while in DWELL, else 0
s0  output  1  select bit 0 (LSB)
s1  output  1  select bit 1
s2  output  1  select bit 2 (MSB)
busy  output  1  high while in DWELL
done  output  1  one-cycle pulse at end of single pass or empty mask

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, s2/s1/s0=0, d=0, busy=0, done=0. Mask and dwell snapshots and the counter clear to 0.
- All outputs registered except d. d = d_in AND (state==DWELL), gated combinationally.
- States are IDLE, DWELL and DONE.
- IDLE, start=1, stop=0, mask!=0:
  - Snapshot mask and dwell.
  - Load the lowest enabled channel index into the select lines.
  - Load counter = max(dwell,1); go to DWELL.
  - Latency: select and busy are valid on the edge after the start-sampling edge.
- IDLE, start=1, mask==0: go to DONE (done pulse on next cycle, busy stays 0).
- IDLE, start and stop both 1: stop wins; remain IDLE.
- DWELL:
  - Counter decrements each cycle; the channel is held for exactly max(dwell,1) cycles.
  - At counter==1, find the next enabled channel above the current index.
  - If one exists: load it, reload counter.
  - If none and continuous=1: wrap to the lowest enabled channel, reload counter.
  - If none and continuous=0: go to DONE.
- DONE: done=1 for exactly one cycle, select lines return to 0, next state IDLE.
- stop=1 in DWELL or DONE: next edge goes to IDLE. done is not asserted on an abort.
- start while busy: ignored.
- Changes to ch_mask, dwell or continuous mid-run: ch_mask and dwell have no effect (snapshots used); continuous is live.
- Single enabled channel with continuous=1: the select stays constant and the counter reloads; there is no glitch on the select lines.
- Illegal state encoding: recover to IDLE.

Decomposition:
- Shared package/include holds:
  - NUM_CH=8 and SEL_W=3.
  - State encodings IDLE=2'd0, DWELL=2'd1, DONE=2'd2.
- One combinational sub-module, demux_next_channel:
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: next[2:0] (next enabled index strictly above cur), found (1 if one exists), first[2:0] (lowest enabled index).
  - Reused for both start and advance.

Test Plan:
1. Reset: assert rst mid-clock with no edge -> all outputs 0 immediately; hold rst and pulse start -> no activity.
2. Full single pass: mask=8'hFF, dwell=5, continuous=0, d_in=1, start for one cycle.
   - {s2,s1,s0} steps 0..7, each held 5 cycles; d=1 and busy=1 throughout.
   - done pulses for one cycle 41 cycles after the start-sampling edge; then busy=0, selects=0.
3. Sparse continuous run: mask=8'b1010_0100, dwell=2, continuous=1.
   - Selects cycle 2,5,7,2,5,..., 2 cycles each.
   - Pulse stop while on ch5 -> IDLE next edge, selects=0, done never asserted.
4. Edge cases:
   - mask=8'h00 with start -> done high exactly one cycle later, busy never high.
   - mask=8'h81, dwell=0 -> ch0 for 1 cycle, ch7 for 1 cycle, then done.
5. Robustness during a run (mask=8'hFF, dwell=4, single pass):
   - Rewrite mask to 8'h01 and pulse start during ch3 -> sequence unchanged through ch7.
   - Toggle d_in -> d follows d_in only while busy.
6. Async reset mid-dwell at ch3 -> outputs clear without a clock edge; after release, a new start begins from the lowest enabled channel.
